parking_exit: RTL

Exit-gate controller for the parking lot; the outbound counterpart of the entrance controller. Validates a 6-bit exit code from a car at the exit sensor, drives the exit door motor against its open/close limit switches, holds the door until the car clears, and emits a one-cycle `carOut` pulse that the shared occupancy counter uses to decrement `carNumber`. Repeated wrong codes or a stalled motor lock the gate with an alarm.

---
 rtl/parking_pkg.sv | 21 ++
 rtl/parking_exit_if.sv | 30 +++
 rtl/parking_down_counter.sv | 32 +++
 rtl/parking_exit.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared parking-lot definitions: gate FSM encoding, code and occupancy widths.
// Used by the entrance and exit gate controllers and their bus interfaces.
package parking_pkg;

    localparam int unsigned PASS_W = 6;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OPENING = 3'd1,
        HOLD    = 3'd2,
        CLOSING = 3'd3,
        LOCKED  = 3'd4
    } gateState_e;

    // True in states where a door motor is driven and the motor timer runs.
    function automatic logic isMotorState(input gateState_e s);
        return (s == OPENING) || (s == CLOSING);
    endfunction

endpackage

// File: rtl/parking_exit_if.sv
// Exit-gate bus: car sensor, code strobe, door limit switches and occupancy in;
// motor commands, code/car pulses and alarm out.
//   master : the gate environment (sensors, keypad, motor driver)
//   slave  : the exit controller
interface parking_exit_if;
    import parking_pkg::*;

    logic              exitSen;
    logic              exitPassValid;
    logic [PASS_W-1:0] exitPass;
    logic              doorMaxOpen;
    logic              doorMaxClose;
    logic [CNT_W-1:0]  carNumber;
    logic              doorOpen;
    logic              doorClose;
    logic              okPass;
    logic              wrongPass;
    logic              carOut;
    logic              alarm;

    modport master (
        output exitSen, exitPassValid, exitPass, doorMaxOpen, doorMaxClose, carNumber,
        input  doorOpen, doorClose, okPass, wrongPass, carOut, alarm
    );

    modport slave (
        input  exitSen, exitPassValid, exitPass, doorMaxOpen, doorMaxClose, carNumber,
        output doorOpen, doorClose, okPass, wrongPass, carOut, alarm
    );
endinterface

// File: rtl/parking_down_counter.sv
// Loadable down counter that stops at zero; used for gate timers.
//   clk, rstN : clock, async active-low reset
//   load      : load loadVal (wins over en)
//   loadVal   : value to load
//   en        : decrement by one while non-zero
//   zero_c    : count is zero (combinational from the count register)
module parking_down_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    input  logic             en,
    output logic             zero_c
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/parking_exit.sv
// Exit-gate controller: checks the exit code, runs the door motor between its
// limit switches, holds the door until the car clears, pulses carOut once per
// door cycle, and locks with an alarm on repeated bad codes or motor faults.
//   clk, rstN : clock, async active-low reset
//   gate      : parking_exit_if.slave bus (all outputs registered)
module parking_exit
    import parking_pkg::*;
#(
    parameter logic [PASS_W-1:0] EXIT_PASS     = 6'd42,
    parameter int unsigned       HOLD_CYCLES   = 16,
    parameter int unsigned       MOTOR_TIMEOUT = 32,
    parameter int unsigned       MAX_TRIES     = 3,
    parameter int unsigned       LOCK_CYCLES   = 64
) (
    input  logic           clk,
    input  logic           rstN,
    parking_exit_if.slave  gate
);

    localparam int unsigned TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned MOTOR_W = $clog2(MOTOR_TIMEOUT + 1);
    localparam int unsigned LOCK_W  = $clog2(LOCK_CYCLES + 1);

    localparam logic [TRY_W-1:0] TRY_MAX  = TRY_W'(MAX_TRIES);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

    gateState_e       state, stateNxt;
    logic [TRY_W-1:0] tries, triesNxt;
    logic             carOutDone, carOutDoneNxt;
    logic             exitSenQ;
    logic             okPassNxt, wrongPassNxt, carOutNxt;
    logic             holdZero, motorZero, lockZero;
    logic             holdLoad, motorLoad, lockLoad;
    logic             bothLimits, senRise, senFall;

    assign bothLimits = gate.doorMaxOpen && gate.doorMaxClose;
    assign senRise    = gate.exitSen && !exitSenQ;
    assign senFall    = !gate.exitSen && exitSenQ;

    // Timers are loaded with N-1 on entry so a state lasts exactly N cycles.
    assign holdLoad  = (stateNxt == HOLD)   && (state != HOLD);
    assign lockLoad  = (stateNxt == LOCKED) && (state != LOCKED);
    assign motorLoad = isMotorState(stateNxt) && (stateNxt != state);

    parking_down_counter #(.WIDTH(HOLD_W)) u_holdTimer (
        .clk(clk), .rstN(rstN), .load(holdLoad),
        .loadVal(HOLD_W'(HOLD_CYCLES - 1)), .en(state == HOLD), .zero_c(holdZero)
    );

    parking_down_counter #(.WIDTH(MOTOR_W)) u_motorTimer (
        .clk(clk), .rstN(rstN), .load(motorLoad),
        .loadVal(MOTOR_W'(MOTOR_TIMEOUT - 1)), .en(isMotorState(state)), .zero_c(motorZero)
    );

    parking_down_counter #(.WIDTH(LOCK_W)) u_lockTimer (
        .clk(clk), .rstN(rstN), .load(lockLoad),
        .loadVal(LOCK_W'(LOCK_CYCLES - 1)), .en(state == LOCKED), .zero_c(lockZero)
    );

    // Next-state, counters and pulse requests.
    always_comb begin
        stateNxt      = state;
        triesNxt      = tries;
        carOutDoneNxt = carOutDone;
        okPassNxt     = 1'b0;
        wrongPassNxt  = 1'b0;
        carOutNxt     = 1'b0;

        unique case (state)
            IDLE: begin
                if (gate.exitPassValid && gate.exitSen) begin
                    if (gate.carNumber == '0) begin
                        // Nobody can be leaving an empty lot; tries untouched.
                        wrongPassNxt = 1'b1;
                    end else if (gate.exitPass == EXIT_PASS) begin
                        okPassNxt     = 1'b1;
                        triesNxt      = '0;
                        carOutDoneNxt = 1'b0;
                        stateNxt      = OPENING;
                    end else begin
                        wrongPassNxt = 1'b1;
                        triesNxt     = (tries >= TRY_MAX) ? tries : tries + TRY_W'(1);
                        if (tries >= TRY_LAST) begin
                            stateNxt = LOCKED;
                        end
                    end
                end
            end
            OPENING: begin
                if (bothLimits) begin
                    stateNxt = LOCKED;
                end else if (gate.doorMaxOpen) begin
                    stateNxt = HOLD;
                end else if (motorZero) begin
                    stateNxt = LOCKED;
                end
            end
            HOLD: begin
                if (senFall && !carOutDone) begin
                    carOutNxt     = 1'b1;
                    carOutDoneNxt = 1'b1;
                end
                if (holdZero && !gate.exitSen && carOutDone) begin
                    stateNxt = CLOSING;
                end
            end
            CLOSING: begin
                // A car reappearing beats the close limit in the same cycle.
                if (bothLimits) begin
                    stateNxt = LOCKED;
                end else if (senRise) begin
                    stateNxt = OPENING;
                end else if (gate.doorMaxClose) begin
                    stateNxt = IDLE;
                end else if (motorZero) begin
                    stateNxt = LOCKED;
                end
            end
            LOCKED: begin
                if (lockZero) begin
                    stateNxt = IDLE;
                    triesNxt = '0;
                end
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; outputs follow the next state so motor
    // commands change in the same cycle as the state.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state          <= IDLE;
            tries          <= '0;
            carOutDone     <= 1'b0;
            exitSenQ       <= 1'b0;
            gate.doorOpen  <= 1'b0;
            gate.doorClose <= 1'b0;
            gate.okPass    <= 1'b0;
            gate.wrongPass <= 1'b0;
            gate.carOut    <= 1'b0;
            gate.alarm     <= 1'b0;
        end else begin
            state          <= stateNxt;
            tries          <= triesNxt;
            carOutDone     <= carOutDoneNxt;
            exitSenQ       <= gate.exitSen;
            gate.doorOpen  <= (stateNxt == OPENING);
            gate.doorClose <= (stateNxt == CLOSING);
            gate.okPass    <= okPassNxt;
            gate.wrongPass <= wrongPassNxt;
            gate.carOut    <= carOutNxt;
            gate.alarm     <= (stateNxt == LOCKED);
        end
    end

endmodule
